// File: rtl/pack_route.sv
// Debounced switch steering a 50-bit video pack to one of two outputs.
// Define PACK_ROUTE_FRAME_SYNC_EN to defer each route change to the next vsync edge.
module pack_route #(
    parameter int DEBOUNCE_TICK = 5_000_000,
    parameter int VS_BIT        = 26,
    parameter int VS_POL        = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        switch,
    input  logic [49:0] i_pack,
    output logic [49:0] o_pack_1,
    output logic [49:0] o_pack_2,
    output logic        o_sel,
    output logic        o_pending
);

    // The counter only ever holds values up to DEBOUNCE_TICK-1, so it cannot wrap.
    localparam int CNT_W = (DEBOUNCE_TICK > 2) ? $clog2(DEBOUNCE_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICK - 1);

    if (VS_BIT < 0 || VS_BIT > 49 || VS_POL < 0 || VS_POL > 1) begin : g_cfg_check
        $error("pack_route: VS_BIT or VS_POL out of range");
    end

    logic [1:0]       sync_r;
    logic             deb_r;
    logic             deb_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_s;
    logic             toggle_s;
    logic             sel_next_s;

    // Two-flop synchronizer for the raw button.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], switch};
        end
    end

    // Debouncer: accept the new level after DEBOUNCE_TICK consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_r      <= 1'b0;
            deb_prev_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            deb_prev_r <= deb_r;
            if (sync_r[1] != deb_r) begin
                if (cnt_r == CNT_MAX) begin
                    deb_r <= sync_r[1];
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign req_s = deb_r & ~deb_prev_r;

`ifdef PACK_ROUTE_FRAME_SYNC_EN
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    localparam logic VS_ACT = 1'(VS_POL);

    state_t state_r;
    logic   vs_d_r;
    logic   vs_edge_s;

    // Delayed vsync for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_d_r <= 1'b0;
        end else begin
            vs_d_r <= i_pack[VS_BIT];
        end
    end

    assign vs_edge_s = (i_pack[VS_BIT] == VS_ACT) && (vs_d_r != VS_ACT);

    // A toggle only lands on a vsync edge while a request is pending.
    always_comb begin
        toggle_s = 1'b0;
        if (state_r == PENDING && vs_edge_s) begin
            toggle_s = 1'b1;
        end else begin
            toggle_s = 1'b0;
        end
    end

    // Request FSM; requests arriving while PENDING are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            o_pending <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        state_r   <= PENDING;
                        o_pending <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        o_pending <= 1'b0;
                    end
                end
                PENDING: begin
                    if (vs_edge_s) begin
                        state_r   <= IDLE;
                        o_pending <= 1'b0;
                    end else begin
                        state_r   <= PENDING;
                        o_pending <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    o_pending <= 1'b0;
                end
            endcase
        end
    end
`else
    // Without frame sync every request flips the route immediately.
    always_comb begin
        toggle_s = 1'b0;
        if (req_s) begin
            toggle_s = 1'b1;
        end else begin
            toggle_s = 1'b0;
        end
    end

    assign o_pending = 1'b0;
`endif

    assign sel_next_s = o_sel ^ toggle_s;

    // Route select and outputs share an edge so a pack never lands on the stale route.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_sel    <= 1'b0;
            o_pack_1 <= 50'd0;
            o_pack_2 <= 50'd0;
        end else begin
            o_sel <= sel_next_s;
            if (sel_next_s) begin
                o_pack_1 <= i_pack;
                o_pack_2 <= 50'd0;
            end else begin
                o_pack_1 <= 50'd0;
                o_pack_2 <= i_pack;
            end
        end
    end

endmodule

// File: doc/pack_route.md
PACK_ROUTE -- requirements
Module: pack_route

Interface
REQ-001 The parameter DEBOUNCE_TICK SHALL default to 5_000_000 and set the cycles the synchronized switch level must stay stable before it is accepted.
REQ-002 The parameter VS_BIT SHALL default to 26 and give the bit index of vsync within the 50-bit pack.
REQ-003 The parameter VS_POL SHALL default to 1 and give the active level of vsync.
REQ-004 The port clk SHALL be an input, 1 bit wide, and be the single clock for all logic.
REQ-005 The port rstn SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-006 The port switch SHALL be an input, 1 bit wide: raw, asynchronous, active-high button.
REQ-007 The port i_pack SHALL be an input, 50 bits wide, and be the source video pack.
REQ-008 The port o_pack_1 SHALL be an output, 50 bits wide, and be route target 1.
REQ-009 The port o_pack_2 SHALL be an output, 50 bits wide, and be route target 2.
REQ-010 The port o_sel SHALL be an output, 1 bit wide: 0 selects route 2 (o_pack_2 active), 1 selects route 1 (o_pack_1 active).
REQ-011 The port o_pending SHALL be an output, 1 bit wide, and be high while an accepted toggle awaits its frame boundary.

Function
REQ-012 switch SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 The debouncer SHALL count consecutive cycles where the synchronized level differs from the debounced level, clear the count on any agreement, and update the debounced level when the count reaches DEBOUNCE_TICK-1.
REQ-014 A 0->1 transition of the debounced level SHALL create one toggle request; a 1->0 transition SHALL create none.
REQ-015 The vsync edge SHALL be the transition of i_pack[VS_BIT] into level VS_POL, detected against a one-cycle-delayed copy of i_pack[VS_BIT].
REQ-016 The FSM SHALL have two states: IDLE and PENDING.
REQ-017 In IDLE, a toggle request SHALL move the FSM to PENDING.
REQ-018 In PENDING, a vsync edge SHALL invert o_sel and move the FSM to IDLE.
REQ-019 A toggle request arriving while in PENDING SHALL be ignored.
REQ-020 A toggle request and a vsync edge in the same IDLE cycle SHALL only enter PENDING; the switch takes effect at the following vsync edge.
REQ-021 o_pending SHALL be 1 exactly when the FSM is in PENDING.
REQ-022 Each cycle, the active output SHALL register i_pack and the inactive output SHALL register 50'b0, giving 1-cycle latency from i_pack to the active output.
REQ-023 The o_sel change and the output re-steering SHALL occur on the same clock edge, so the first pack after the vsync edge appears only on the new active output.
REQ-024 The debounce counter SHALL be wide enough for DEBOUNCE_TICK and SHALL never wrap.

Reset
REQ-025 When rstn=0, o_sel SHALL be 0, the FSM SHALL be IDLE, o_pending SHALL be 0, o_pack_1 and o_pack_2 SHALL be 0, the synchronizer and debounced level SHALL be 0, the counter SHALL be 0, and the delayed vsync SHALL be 0.
REQ-026 A reset asserted while in PENDING SHALL discard the pending toggle.
REQ-027 A switch held high through reset release SHALL generate one toggle request once it has been debounced.

Configuration
REQ-028 With PACK_ROUTE_FRAME_SYNC_EN defined, switching SHALL follow REQ-016..REQ-021.
REQ-029 Without PACK_ROUTE_FRAME_SYNC_EN, a toggle request SHALL invert o_sel on the next clock edge, o_pending SHALL be tied to 0, and the vsync-edge logic SHALL be absent.

Verification (DEBOUNCE_TICK=4, VS_BIT=26, VS_POL=1, PACK_ROUTE_FRAME_SYNC_EN defined unless stated)
REQ-030 Release reset and drive i_pack=50'h123 -> the bench SHALL see o_sel=0, o_pack_2=50'h123 one cycle later, and o_pack_1=0.
REQ-031 Pulse switch high for 3 cycles -> the bench SHALL see no request, with o_pending staying 0 and o_sel staying 0.
REQ-032 Hold switch high for 10 cycles, then raise bit 26 -> the bench SHALL see o_pending=1 until the vsync edge, then o_sel=1 and o_pending=0 on that edge, with o_pack_1 carrying i_pack and o_pack_2=0 from the next cycle.
REQ-033 Make a second debounced press while PENDING -> the bench SHALL see exactly one toggle of o_sel at the next vsync edge.
REQ-034 Assert rstn=0 while PENDING, then release -> the bench SHALL see o_sel=0 and o_pending=0, and vsync edges SHALL cause no toggle.
REQ-035 Without PACK_ROUTE_FRAME_SYNC_EN, hold switch high for 10 cycles with no vsync -> the bench SHALL see o_sel toggle 1 cycle after the debounced rise.
